// File: rtl/seq_table_counter.sv
// Programmable sequence counter: steps an index through a writable value table,
// forward or reverse, looping or one-shot, with a registered terminal-count pulse.
module seq_table_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             restart,
    input  logic [AW:0]      len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic [AW-1:0]    idx,
    output logic             tc,
    output logic             done
);

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] seq_tab [DEPTH];

    logic [AW:0]      len_eff;
    logic [AW-1:0]    last_pos;
    logic [AW-1:0]    first_idx;
    logic [AW-1:0]    term_idx;
    logic [AW-1:0]    idx_d;
    logic             done_d;
    logic             tc_d;
    logic [WIDTH-1:0] count_d;
    logic             wr_ok;

    assign wr_ok = ({1'b0, wr_addr} < DepthW);

    always_comb begin
        len_eff   = ((len == '0) || (len > DepthW)) ? DepthW : len;
        last_pos  = AW'(len_eff - (AW+1)'(1));
        first_idx = dir ? last_pos : '0;
        term_idx  = dir ? '0 : last_pos;

        idx_d  = idx;
        done_d = done;
        tc_d   = 1'b0;

        if (restart) begin
            idx_d  = first_idx;
            done_d = 1'b0;
        end else if (en && !done) begin
            // Index left beyond a shortened length: resume at the start, not a terminal step.
            if (idx > last_pos) begin
                idx_d = first_idx;
            end else if (idx == term_idx) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    done_d = 1'b1;
                end else begin
                    idx_d = first_idx;
                end
            end else begin
                idx_d = dir ? (idx - AW'(1)) : (idx + AW'(1));
            end
        end

        // Same-cycle write to the next index is forwarded so count never shows stale data.
        count_d = (wr_en && (wr_addr == idx_d)) ? wr_data : seq_tab[idx_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                seq_tab[i] <= WIDTH'(i);
            end
        end else if (wr_en && wr_ok) begin
            seq_tab[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            idx   <= idx_d;
            count <= count_d;
            tc    <= tc_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_table_counter.sv
// Self-checking bench for seq_table_counter: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_seq_table_counter;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en, dir, oneshot, restart;
    logic [AW:0]      len;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] count;
    logic [AW-1:0]    idx;
    logic             tc, done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_idx, m_count, m_tc, m_done;
    int m_tab [DEPTH];

    typedef struct {
        int en, dir, os, rs, len, wr_en, wr_addr, wr_data;
        int exp_count, exp_idx, exp_tc, exp_done;
    } vec_t;
    vec_t vq[$];

    seq_table_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .dir     (dir),
        .oneshot (oneshot),
        .restart (restart),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .idx     (idx),
        .tc      (tc),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_count = 0; m_tc = 0; m_done = 0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = i % (1 << WIDTH);
    endtask

    // Next state from the sequencing rules, using the inputs currently applied.
    task automatic model_step();
        int l, f, t, n;
        l = (len == 0 || int'(len) > DEPTH) ? DEPTH : int'(len);
        f = dir ? l - 1 : 0;
        t = dir ? 0 : l - 1;
        n = m_idx;
        m_tc = 0;
        if (restart) begin
            n = f;
            m_done = 0;
        end else if (en && m_done == 0) begin
            if (m_idx > l - 1) n = f;
            else if (m_idx == t) begin
                m_tc = 1;
                if (oneshot) m_done = 1;
                else n = f;
            end else n = dir ? m_idx - 1 : m_idx + 1;
        end
        m_idx = n;
        m_count = (wr_en && int'(wr_addr) == n) ? int'(wr_data) : m_tab[n];
        if (wr_en && int'(wr_addr) < DEPTH) m_tab[wr_addr] = int'(wr_data);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".idx"},   32'(idx),   32'(m_idx));
        chk({tag, ".tc"},    32'(tc),    32'(m_tc));
        chk({tag, ".done"},  32'(done),  32'(m_done));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        cmp_model("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_model("reset_hold");
    endtask

    task automatic set_in(input int e, input int d, input int o, input int r, input int l);
        en = e[0]; dir = d[0]; oneshot = o[0]; restart = r[0]; len = (AW+1)'(l);
    endtask

    task automatic add(input int e, d, o, r, l, we, wa, wd, ec, ei, et, ed);
        vec_t v;
        v.en = e; v.dir = d; v.os = o; v.rs = r; v.len = l;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.exp_count = ec; v.exp_idx = ei; v.exp_tc = et; v.exp_done = ed;
        vq.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Free run from reset with identity table, len=0 -> full depth
        for (int i = 1; i <= 10; i++) add(1, 0, 0, 0, 0, 0, 0, 0, i % 8, i % 8, (i == 8), 0);
        // Load table while halted at idx 2; write to idx 2 is bypassed into count
        add(0, 0, 0, 0, 0, 1, 0, 0,  2, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 2,  2, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 2, 5,  5, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 3, 8,  5, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4, 11, 5, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 5, 14, 5, 2, 0, 0);
        // len=6 loop forward
        add(1, 0, 0, 1, 6, 0, 0, 0, 0,  0, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 2,  1, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 5,  2, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 8,  3, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 11, 4, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 14, 5, 0, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 0,  0, 1, 0);
        add(1, 0, 0, 0, 6, 0, 0, 0, 2,  1, 0, 0);
        // Reverse one-shot
        add(1, 1, 1, 1, 6, 0, 0, 0, 14, 5, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 11, 4, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 8,  3, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 5,  2, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 2,  1, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 0,  0, 0, 0);
        add(1, 1, 1, 0, 6, 0, 0, 0, 0,  0, 1, 1);
        add(1, 1, 1, 0, 6, 0, 0, 0, 0,  0, 0, 1);
        add(1, 1, 1, 0, 6, 0, 0, 0, 0,  0, 0, 1);
        add(1, 1, 0, 0, 6, 0, 0, 0, 0,  0, 0, 1);
        add(1, 1, 1, 1, 6, 0, 0, 0, 14, 5, 0, 0);

        do_reset();

        foreach (vq[k]) begin
            set_in(vq[k].en, vq[k].dir, vq[k].os, vq[k].rs, vq[k].len);
            wr_en = vq[k].wr_en[0]; wr_addr = AW'(vq[k].wr_addr); wr_data = WIDTH'(vq[k].wr_data);
            step("vec_model");
            chk($sformatf("vec%0d.count", k), 32'(count), 32'(vq[k].exp_count));
            chk($sformatf("vec%0d.idx", k),   32'(idx),   32'(vq[k].exp_idx));
            chk($sformatf("vec%0d.tc", k),    32'(tc),    32'(vq[k].exp_tc));
            chk($sformatf("vec%0d.done", k),  32'(done),  32'(vq[k].exp_done));
        end
        wr_en = 1'b0;

        // Write bypass during an advance, then seen again on the next pass
        set_in(1, 0, 0, 0, 6);
        step("wrap_fwd");
        chk("wrap_fwd.tc", 32'(tc), 32'd1);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd9;
        step("bypass");
        chk("bypass.count", 32'(count), 32'd9);
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step("bypass_pass");
        chk("bypass_pass.count", 32'(count), 32'd9);

        // Shrinking len past the current index resumes at F without tc
        set_in(1, 0, 0, 1, 8);
        step("len8_restart");
        set_in(1, 0, 0, 0, 8);
        for (int i = 0; i < 6; i++) step("len8_run");
        chk("len8_run.idx", 32'(idx), 32'd6);
        set_in(1, 0, 0, 0, 4);
        step("len_shrink");
        chk("len_shrink.idx", 32'(idx), 32'd0);
        chk("len_shrink.tc", 32'(tc), 32'd0);
        step("len4_run");
        step("len4_run");

        // Mid-sequence reset, then identity table back in force
        do_reset();
        chk("midreset.idx", 32'(idx), 32'd0);
        set_in(1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step("identity");
            chk($sformatf("identity%0d.count", i), 32'(count), 32'(i % 8));
        end

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                en      = ($urandom_range(0, 3) != 0);
                dir     = ($urandom_range(0, 5) == 0) ? ~dir : dir;
                oneshot = ($urandom_range(0, 3) == 0);
                restart = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 9) == 0) len = (AW+1)'($urandom_range(0, 15));
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = AW'($urandom);
                wr_data = WIDTH'($urandom);
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
